// File: rtl/md_ctrl.sv
// md_ctrl: radix-2 multiply/divide sequencer owning HI/LO, with pipeline stall generation.
// Operands are latched as magnitudes; the sign is restored in the FIX cycle.
module md_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] md_a,
  input  logic [WIDTH-1:0] md_b,
  input  logic             mf_req,
  input  logic             md_flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             md_busy,
  output logic             md_done,
  output logic             md_pause
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;
  stateT state, stateNext;
  logic [2*WIDTH-1:0] acc, prod, divNext;
  logic [WIDTH-1:0] opB, absA, absB, quot, remOut;
  logic [WIDTH:0] mulSum, remShift, divTrial;
  logic [CW-1:0] cnt;
  logic isDiv, negQ, negR, divZero;
  logic opMul, opDiv, opSigned, opValid, startOp, bZero;
  assign opMul    = md_op == 3'd1 || md_op == 3'd2;
  assign opDiv    = md_op == 3'd3 || md_op == 3'd4;
  assign opSigned = md_op == 3'd1 || md_op == 3'd3;
  assign opValid  = md_op != 3'd0 && md_op != 3'd7;
  assign startOp  = opMul || opDiv;
  assign bZero    = md_b == '0;
  assign absA     = opSigned && md_a[WIDTH-1] ? -md_a : md_a;
  assign absB     = opSigned && md_b[WIDTH-1] ? -md_b : md_b;
  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opB} : {(WIDTH+1){1'b0}});
  assign remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign divTrial = remShift - {1'b0, opB};
  assign divNext  = {divTrial[WIDTH] ? remShift[WIDTH-1:0] : divTrial[WIDTH-1:0], acc[WIDTH-2:0], ~divTrial[WIDTH]};
  assign prod     = negQ ? -acc : acc;
  assign quot     = negQ ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign remOut   = negR ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  always_ff @(posedge clk)
    state <= !clrn ? IDLE : stateNext;
  always_comb begin
    stateNext = state;
    md_busy   = state != IDLE;
    md_pause  = md_busy && (opValid || mf_req);
    if (md_flush)
      stateNext = IDLE;
    else if (state == IDLE && startOp)
      stateNext = opDiv && bZero ? FIX : RUN;
    else if (state == RUN && cnt == CW'(1))
      stateNext = FIX;
    else if (state == FIX)
      stateNext = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!clrn) begin
      hi      <= '0;
      lo      <= '0;
      md_done <= 1'b0;
      acc     <= '0;
      opB     <= '0;
      cnt     <= '0;
      isDiv   <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      divZero <= 1'b0;
    end else if (md_flush) begin
      md_done <= 1'b0;
    end else begin
      md_done <= state == FIX;
      if (state == IDLE) begin
        if (md_op == 3'd5) hi <= md_a;
        if (md_op == 3'd6) lo <= md_a;
        if (startOp) begin
          acc     <= {{WIDTH{1'b0}}, opDiv && bZero ? md_a : absA};
          opB     <= absB;
          cnt     <= CW'(WIDTH);
          isDiv   <= opDiv;
          divZero <= opDiv && bZero;
          negQ    <= opSigned && (md_a[WIDTH-1] ^ md_b[WIDTH-1]);
          negR    <= opSigned && md_a[WIDTH-1];
        end
      end else if (state == RUN) begin
        acc <= isDiv ? divNext : {mulSum, acc[WIDTH-1:1]};
        cnt <= cnt - CW'(1);
      end else if (divZero) begin
        hi <= acc[WIDTH-1:0];
        lo <= '1;
      end else if (isDiv) begin
        hi <= remOut;
        lo <= quot;
      end else begin
        {hi, lo} <= prod;
      end
    end
  end
endmodule
